// File: rtl/mem_copy_pkg.sv
// ---------------------------------------------------------------------------
// mem_copy_pkg
// Shared definitions for the word-granular memory copy engine:
//   copyState_t     - FSM state encoding (IDLE, READ, WRITE, DONE)
//   WORD_BYTES      - byte stride between consecutive words
//   DEFAULT_ADDR_W  - default byte-address width (32 words of 4 bytes)
//   DEFAULT_DATA_W  - default memory word width
// ---------------------------------------------------------------------------
package mem_copy_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int DEFAULT_ADDR_W = 7;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copyState_t;

endpackage

// File: rtl/mem_copy_engine.sv
// ---------------------------------------------------------------------------
// mem_copy_engine
// Copies `length` 32-bit words from src_addr to dst_addr in a single-port
// memory, strictly forward, alternating one READ and one WRITE cycle per word.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   start               - one-cycle copy request, honoured only in IDLE
//   src_addr, dst_addr  - word-aligned byte start addresses
//   length              - number of words to copy (0..32)
//   busy                - high in READ and WRITE
//   done                - one-cycle completion pulse
//   err                 - sticky misalignment flag, cleared by the next start
//   WriteEnable         - memory write strobe
//   address             - memory byte address (zero when not copying)
//   WriteData           - memory write data (zero when not writing)
//   MemData             - combinational read data for `address`
//   checksum            - (MEM_COPY_CHECKSUM_EN only) wrap-around sum of the
//                         words written by the last copy
//
// Configuration macro: MEM_COPY_CHECKSUM_EN
// ---------------------------------------------------------------------------
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [5:0]        length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] MemData
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] ptrStep = ADDR_W'(WORD_BYTES);

    copyState_t        state;
    copyState_t        nextState;
    logic [ADDR_W-1:0] srcPtr;
    logic [ADDR_W-1:0] dstPtr;
    logic [5:0]        count;
    logic [DATA_W-1:0] dataBuf;
    logic              misaligned;

    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and Moore outputs; the memory bus is driven only while busy.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        nextState   = state;
        busy        = 1'b0;
        done        = 1'b0;
        WriteEnable = 1'b0;
        address     = '0;
        WriteData   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    // Misaligned or empty requests finish without touching memory.
                    if (misaligned || (length == 6'd0)) begin
                        nextState = DONE;
                    end else begin
                        nextState = READ;
                    end
                end
            end
            READ: begin
                busy      = 1'b1;
                address   = srcPtr;
                nextState = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                WriteEnable = 1'b1;
                address     = dstPtr;
                WriteData   = dataBuf;
                // count still holds the pre-decrement value here.
                nextState   = (count == 6'd1) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            srcPtr   <= '0;
            dstPtr   <= '0;
            count    <= '0;
            dataBuf  <= '0;
            err      <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        srcPtr   <= src_addr;
                        dstPtr   <= dst_addr;
                        count    <= length;
                        err      <= misaligned;
`ifdef MEM_COPY_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                READ: begin
                    dataBuf <= MemData;
                end
                WRITE: begin
                    srcPtr   <= srcPtr + ptrStep;
                    dstPtr   <= dstPtr + ptrStep;
                    count    <= count - 6'd1;
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum <= checksum + dataBuf;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_mem_copy_engine
// Bench for mem_copy_engine with a DataMemory model. Expected memory accesses
// and completions come from a word-array reference model and are queued when
// a copy is issued; a negedge monitor pops and compares them as the DUT
// presents bus activity and done pulses.
// DataMemory: single-port word memory, combinational read, clocked write,
// plus a bench-only preload port.
// Configuration macro: MEM_COPY_CHECKSUM_EN (adds checksum checks).
// ---------------------------------------------------------------------------
module DataMemory #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] MemData,
    input  logic              loadEn,
    input  logic [ADDR_W-3:0] loadIdx,
    input  logic [DATA_W-1:0] loadData
);
    localparam int WORDS = 1 << (ADDR_W - 2);

    // NOTE: the storage array has no reset, so words written before an
    // aborted copy survive a reset of the engine.
    logic [DATA_W-1:0] Mem [WORDS];

    assign MemData = Mem[address[ADDR_W-1:2]];

    always_ff @(posedge clock) begin
        if (loadEn) begin
            Mem[loadIdx] <= loadData;
        end else if (WriteEnable) begin
            Mem[address[ADDR_W-1:2]] <= WriteData;
        end
    end
endmodule

module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int AW    = DEFAULT_ADDR_W;
    localparam int DW    = DEFAULT_DATA_W;
    localparam int WORDS = 1 << (AW - 2);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [5:0]    length = '0;
    logic          busy, done, err, WriteEnable;
    logic [AW-1:0] address;
    logic [DW-1:0] WriteData, MemData;
    logic          loadEn = 1'b0;
    logic [AW-3:0] loadIdx = '0;
    logic [DW-1:0] loadData = '0;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .WriteEnable (WriteEnable),
        .address     (address),
        .WriteData   (WriteData),
        .MemData     (MemData)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    DataMemory #(.ADDR_W(AW), .DATA_W(DW)) u_mem (
        .clock       (clock),
        .WriteEnable (WriteEnable),
        .address     (address),
        .WriteData   (WriteData),
        .MemData     (MemData),
        .loadEn      (loadEn),
        .loadIdx     (loadIdx),
        .loadData    (loadData)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit            isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } access_t;

    typedef struct {
        int startCycle;
        int latency;
        bit err;
    } doneExp_t;

    access_t       accQ[$];
    doneExp_t      doneQ[$];
    logic [DW-1:0] model [WORDS];
    logic [DW-1:0] expSum = '0;
    int            writesSeen = 0;
    int            checks = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    access_t  monAcc;
    doneExp_t monDone;

    always @(negedge clock) begin
        if (!reset) begin
            if (busy) begin
                if (accQ.size() == 0) begin
                    check("unexpected_access", {63'd0, busy}, 64'd0);
                end else begin
                    monAcc = accQ.pop_front();
                    check("access_kind", {63'd0, WriteEnable}, {63'd0, monAcc.isWrite});
                    check("access_addr", {57'd0, address}, {57'd0, monAcc.addr});
                    if (monAcc.isWrite) begin
                        check("write_data", {32'd0, WriteData}, {32'd0, monAcc.data});
                        writesSeen++;
                    end
                end
            end else begin
                check("idle_we", {63'd0, WriteEnable}, 64'd0);
                check("idle_addr", {57'd0, address}, 64'd0);
                check("idle_wdata", {32'd0, WriteData}, 64'd0);
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    monDone = doneQ.pop_front();
                    check("done_latency", 64'(cycle - monDone.startCycle + 1), 64'(monDone.latency));
                    check("done_err", {63'd0, err}, {63'd0, monDone.err});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int idx, input logic [DW-1:0] value);
        @(negedge clock);
        loadEn   = 1'b1;
        loadIdx  = idx[AW-3:0];
        loadData = value;
        @(posedge clock);
        #1;
        loadEn   = 1'b0;
        model[idx] = value;
    endtask

    // Issue a copy and queue the model's expectations. `keep` is how many
    // writes will really land (less than len only when the copy is aborted).
    task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int len, input int keep);
        bit            mis;
        doneExp_t      de;
        access_t       r;
        access_t       w;
        int            si;
        int            di;
        logic [DW-1:0] word;
        mis = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        @(negedge clock);
        src_addr = s;
        dst_addr = d;
        length   = 6'(len);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        de.startCycle = cycle;
        de.latency    = mis ? 1 : 2 * len + 1;
        de.err        = mis;
        if (keep == len) doneQ.push_back(de);
        expSum = '0;
        if (!mis) begin
            for (int i = 0; i < len; i++) begin
                si   = (int'(s) / WORD_BYTES + i) % WORDS;
                di   = (int'(d) / WORD_BYTES + i) % WORDS;
                word = model[si];
                r.isWrite = 1'b0;
                r.addr    = AW'(int'(s) + WORD_BYTES * i);
                r.data    = '0;
                w.isWrite = 1'b1;
                w.addr    = AW'(int'(d) + WORD_BYTES * i);
                w.data    = word;
                accQ.push_back(r);
                accQ.push_back(w);
                if (i < keep) begin
                    model[di] = word;
                    expSum    = expSum + word;
                end
            end
        end
        check("err_after_start", {63'd0, err}, {63'd0, mis});
    endtask

    task automatic finishCopy(input int len, input bit mis, input int wBefore);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (doneQ.size() != 0 && n < 2 * len + 10) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("done_seen", 64'(doneQ.size()), 64'd0);
        check("accesses_left", 64'(accQ.size()), 64'd0);
        check("write_count", 64'(writesSeen - wBefore), mis ? 64'd0 : 64'(len));
        for (int i = 0; i < WORDS; i++) begin
            if (u_mem.Mem[i] !== model[i]) bad++;
        end
        check("mem_contents", 64'(bad), 64'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("checksum", {32'd0, checksum}, {32'd0, expSum});
`endif
        doneQ.delete();
        accQ.delete();
    endtask

    task automatic copyAndCheck(input logic [AW-1:0] s, input logic [AW-1:0] d, input int len);
        int wBefore;
        bit mis;
        wBefore = writesSeen;
        mis = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        issue(s, d, len, len);
        finishCopy(len, mis, wBefore);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] old30;
        logic [DW-1:0] old31;
        logic [AW-1:0] rs;
        logic [AW-1:0] rd;
        int            rl;
        int            wBefore;

        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_we", {63'd0, WriteEnable}, 64'd0);
        check("rst_addr", {57'd0, address}, 64'd0);
        check("rst_wdata", {32'd0, WriteData}, 64'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("rst_checksum", {32'd0, checksum}, 64'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < WORDS; i++) load(i, DW'($urandom));

        // Basic four-word copy.
        load(0, 32'h11);
        load(1, 32'h22);
        load(2, 32'h33);
        load(3, 32'h44);
        copyAndCheck(7'h00, 7'h40, 4);
        for (int i = 0; i < 4; i++) begin
            check("basic_dst_word", {32'd0, u_mem.Mem[16 + i]}, 64'(32'h11 * (i + 1)));
        end

        // Zero length, then a misaligned start during DONE must be ignored.
        wBefore = writesSeen;
        issue(7'h10, 7'h20, 0, 0);
        src_addr = 7'h03;
        length   = 6'd5;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        finishCopy(0, 1'b0, wBefore);
        repeat (4) @(negedge clock);
        check("start_in_done_ignored_err", {63'd0, err}, 64'd0);

        // Misalignment: sticky err, cleared by the next accepted start.
        copyAndCheck(7'h02, 7'h40, 4);
        repeat (3) @(negedge clock);
        check("err_sticky", {63'd0, err}, 64'd1);
        copyAndCheck(7'h04, 7'h44, 1);
        copyAndCheck(7'h00, 7'h41, 2);

        // Source pointer wrap.
        old30 = model[30];
        old31 = model[31];
        copyAndCheck(7'h78, 7'h00, 3);
        check("wrap_word0", {32'd0, u_mem.Mem[0]}, {32'd0, old30});
        check("wrap_word1", {32'd0, u_mem.Mem[1]}, {32'd0, old31});
        check("wrap_word2", {32'd0, u_mem.Mem[2]}, {32'd0, old30});

        // start pulsed mid-copy is ignored.
        wBefore = writesSeen;
        issue(7'h00, 7'h40, 6, 6);
        repeat (3) @(posedge clock);
        #1;
        src_addr = 7'h08;
        dst_addr = 7'h10;
        length   = 6'd3;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        finishCopy(6, 1'b0, wBefore);

        // Reset after the second write of an eight-word copy.
        wBefore = writesSeen;
        issue(7'h20, 7'h60, 8, 2);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_we", {63'd0, WriteEnable}, 64'd0);
        check("abort_addr", {57'd0, address}, 64'd0);
        accQ.delete();
        doneQ.delete();
        @(negedge clock);
        reset = 1'b0;
        check("abort_write_count", 64'(writesSeen - wBefore), 64'd2);
`ifdef MEM_COPY_CHECKSUM_EN
        check("abort_checksum", {32'd0, checksum}, 64'd0);
`endif
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < WORDS; i++) if (u_mem.Mem[i] !== model[i]) bad++;
            check("abort_mem_contents", 64'(bad), 64'd0);
        end
        copyAndCheck(7'h10, 7'h30, 5);

        // Full-size copy with overlapping regions.
        copyAndCheck(7'h00, 7'h08, 32);

`ifdef MEM_COPY_CHECKSUM_EN
        load(0, 32'hA5A5A5A5);
        load(1, 32'h5A5A5A5B);
        copyAndCheck(7'h00, 7'h40, 2);
        check("checksum_wrap", {32'd0, checksum}, 64'd0);
        repeat (3) @(negedge clock);
        check("checksum_hold", {32'd0, checksum}, 64'd0);
`endif

        // Randomized copies, occasionally misaligned.
        for (int k = 0; k < 25; k++) begin
            rs = AW'($urandom_range(0, WORDS - 1) * WORD_BYTES);
            rd = AW'($urandom_range(0, WORDS - 1) * WORD_BYTES);
            rl = int'($urandom_range(0, 32));
            if ($urandom_range(0, 7) == 0) rs = rs | AW'($urandom_range(1, 3));
            copyAndCheck(rs, rd, rl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
